// File: rtl/dtw_pe_pipe.sv
// DTW processing element: selects T/R operand vectors, computes the local
// distance (L1 or L-inf) and the minimum predecessor cost, then adds them
// with saturation. Two-stage pipeline with valid/ready flow control.
module dtw_pe_pipe #(
   parameter int unsigned NDIM = 3,
   parameter int unsigned FW   = 10,
   parameter int unsigned DW   = 16,
   parameter int unsigned IW   = 5
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 ena,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        D0,
   input  logic [DW-1:0]        D1,
   input  logic [DW-1:0]        D2,
   input  logic [NDIM*FW-1:0]   T_prev,
   input  logic [NDIM*FW-1:0]   T_global,
   input  logic [NDIM*FW-1:0]   R_prev,
   input  logic [NDIM*FW-1:0]   R_global,
   input  logic [IW-1:0]        i_tindex_prev,
   input  logic [IW-1:0]        i_tindex_global,
   input  logic [IW-1:0]        i_rindex_prev,
   input  logic [IW-1:0]        i_rindex_global,
   input  logic [1:0]           i_tsrc,
   input  logic [1:0]           i_rsrc,
   input  logic                 mode,
   output logic [NDIM*FW-1:0]   T,
   output logic [NDIM*FW-1:0]   R,
   output logic [IW-1:0]        o_tindex,
   output logic [IW-1:0]        o_rindex,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        D,
   output logic [1:0]           o_path,
   output logic                 o_sat
);

   localparam int unsigned VW = NDIM * FW;
   localparam int unsigned LW = FW + 1 + $clog2(NDIM);

   logic [VW-1:0] t_sel;
   logic [VW-1:0] r_sel;
   logic [IW-1:0] ti_sel;
   logic [IW-1:0] ri_sel;
   logic [FW:0]   t_ext;
   logic [FW:0]   r_ext;
   logic [FW:0]   diff;
   logic [FW:0]   mag;
   logic [LW-1:0] l1_sum;
   logic [LW-1:0] linf_max;
   logic [LW-1:0] local_dist;
   logic [DW-1:0] min_cost;
   logic [1:0]    min_path;
   logic          s1_valid;
   logic [LW-1:0] s1_local;
   logic [DW-1:0] s1_min;
   logic [1:0]    s1_path;
   logic          adv2;
   logic          accept;
   logic [DW:0]   total;

   // Flow control: stage 2 drains when empty or consumed; stage 1 frees when it can pass on
   assign adv2     = ~out_valid | out_ready;
   assign in_ready = ena & (~s1_valid | adv2);
   assign accept   = in_valid & in_ready;
   assign total    = {1'b0, s1_min} + (DW+1)'(s1_local);

   // Operand source select; codes 0 and 3 keep the current register contents
   always_comb begin
      t_sel  = T;
      ti_sel = o_tindex;
      r_sel  = R;
      ri_sel = o_rindex;
      case (i_tsrc)
         2'd1:    begin t_sel = T_prev;   ti_sel = i_tindex_prev;   end
         2'd2:    begin t_sel = T_global; ti_sel = i_tindex_global; end
         default: ;
      endcase
      case (i_rsrc)
         2'd1:    begin r_sel = R_prev;   ri_sel = i_rindex_prev;   end
         2'd2:    begin r_sel = R_global; ri_sel = i_rindex_global; end
         default: ;
      endcase
   end

   // Per-channel |R_k - T_k| in FW+1 bits, reduced by sum or max
   always_comb begin
      l1_sum   = '0;
      linf_max = '0;
      t_ext    = '0;
      r_ext    = '0;
      diff     = '0;
      mag      = '0;
      for (int k = 0; k < NDIM; k++) begin
         t_ext = {t_sel[k*FW+FW-1], t_sel[k*FW +: FW]};
         r_ext = {r_sel[k*FW+FW-1], r_sel[k*FW +: FW]};
         diff  = r_ext - t_ext;
         mag   = diff[FW] ? (~diff + (FW+1)'(1)) : diff;
         l1_sum = l1_sum + LW'(mag);
         if (LW'(mag) > linf_max) linf_max = LW'(mag);
      end
      local_dist = mode ? linf_max : l1_sum;
   end

   // Predecessor minimum with priority D0 > D1 > D2 on ties
   always_comb begin
      min_cost = D2;
      min_path = 2'b01;
      if ((D0 <= D1) && (D0 <= D2)) begin
         min_cost = D0;
         min_path = 2'b11;
      end else if (D1 <= D2) begin
         min_cost = D1;
         min_path = 2'b10;
      end
   end

   // Operand registers, forwarded to the neighbouring element
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         T        <= '0;
         R        <= '0;
         o_tindex <= '1;
         o_rindex <= '1;
      end else if (!ena) begin
         T        <= '0;
         R        <= '0;
         o_tindex <= '1;
         o_rindex <= '1;
      end else if (accept) begin
         T        <= t_sel;
         R        <= r_sel;
         o_tindex <= ti_sel;
         o_rindex <= ri_sel;
      end
   end

   // Stage 1: local distance, minimum cost and path
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         s1_valid <= 1'b0;
         s1_local <= '0;
         s1_min   <= '0;
         s1_path  <= 2'b00;
      end else if (!ena) begin
         s1_valid <= 1'b0;
         s1_local <= '0;
         s1_min   <= '0;
         s1_path  <= 2'b00;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_local <= local_dist;
         s1_min   <= min_cost;
         s1_path  <= min_path;
      end else if (adv2) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: saturating accumulate, held while the consumer stalls
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         out_valid <= 1'b0;
         D         <= '0;
         o_path    <= 2'b00;
         o_sat     <= 1'b0;
      end else if (!ena) begin
         out_valid <= 1'b0;
         D         <= '0;
         o_path    <= 2'b00;
         o_sat     <= 1'b0;
      end else if (adv2) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            D      <= total[DW] ? '1 : total[DW-1:0];
            o_path <= s1_path;
            o_sat  <= total[DW];
         end
      end
   end

endmodule

// File: tb/tb_dtw_pe_pipe.sv
// Self-checking bench for dtw_pe_pipe: directed cases plus randomized traffic
// scored against an arithmetic reference model.
module tb_dtw_pe_pipe;

   localparam int unsigned NDIM = 3;
   localparam int unsigned FW   = 10;
   localparam int unsigned DW   = 16;
   localparam int unsigned IW   = 5;
   localparam int unsigned VW   = NDIM * FW;

   typedef struct {
      logic [DW-1:0] d;
      logic [1:0]    path;
      logic          sat;
      int            cyc;
   } exp_t;

   logic          clk;
   logic          nrst;
   logic          ena;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] D0, D1, D2;
   logic [VW-1:0] T_prev, T_global, R_prev, R_global;
   logic [IW-1:0] i_tindex_prev, i_tindex_global, i_rindex_prev, i_rindex_global;
   logic [1:0]    i_tsrc, i_rsrc;
   logic          mode;
   logic [VW-1:0] T, R;
   logic [IW-1:0] o_tindex, o_rindex;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] D;
   logic [1:0]    o_path;
   logic          o_sat;

   int            n_chk;
   int            n_pass;
   int            cyc;
   bit            lat_chk;
   exp_t          q[$];
   logic [VW-1:0] sh_t, sh_r;
   logic [IW-1:0] sh_ti, sh_ri;

   dtw_pe_pipe #(.NDIM(NDIM), .FW(FW), .DW(DW), .IW(IW)) dut (
      .clk(clk), .nrst(nrst), .ena(ena),
      .in_valid(in_valid), .in_ready(in_ready),
      .D0(D0), .D1(D1), .D2(D2),
      .T_prev(T_prev), .T_global(T_global), .R_prev(R_prev), .R_global(R_global),
      .i_tindex_prev(i_tindex_prev), .i_tindex_global(i_tindex_global),
      .i_rindex_prev(i_rindex_prev), .i_rindex_global(i_rindex_global),
      .i_tsrc(i_tsrc), .i_rsrc(i_rsrc), .mode(mode),
      .T(T), .R(R), .o_tindex(o_tindex), .o_rindex(o_rindex),
      .out_valid(out_valid), .out_ready(out_ready),
      .D(D), .o_path(o_path), .o_sat(o_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   // Reference: sum/max of channel absolute differences plus cheapest predecessor
   function automatic exp_t ref_result(input logic [VW-1:0] tv, input logic [VW-1:0] rv,
                                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                       input logic [DW-1:0] d2, input logic m);
      exp_t e;
      int s, mx, a, mn, tot;
      s  = 0;
      mx = 0;
      for (int k = 0; k < NDIM; k++) begin
         a = int'($signed(rv[k*FW +: FW])) - int'($signed(tv[k*FW +: FW]));
         if (a < 0) a = -a;
         s = s + a;
         if (a > mx) mx = a;
      end
      mn = int'(d0);
      if (int'(d1) < mn) mn = int'(d1);
      if (int'(d2) < mn) mn = int'(d2);
      if (int'(d0) == mn)      e.path = 2'b11;
      else if (int'(d1) == mn) e.path = 2'b10;
      else                     e.path = 2'b01;
      tot   = (m ? mx : s) + mn;
      e.sat = (tot > 65535);
      e.d   = (tot > 65535) ? 16'hFFFF : 16'(tot);
      e.cyc = 0;
      return e;
   endfunction

   function automatic logic [VW-1:0] pick_v(input logic [1:0] s, input logic [VW-1:0] h,
                                            input logic [VW-1:0] p, input logic [VW-1:0] g);
      return (s == 2'd1) ? p : (s == 2'd2) ? g : h;
   endfunction

   function automatic logic [IW-1:0] pick_i(input logic [1:0] s, input logic [IW-1:0] h,
                                            input logic [IW-1:0] p, input logic [IW-1:0] g);
      return (s == 2'd1) ? p : (s == 2'd2) ? g : h;
   endfunction

   task automatic model_clear();
      q.delete();
      sh_t  = '0;
      sh_r  = '0;
      sh_ti = '1;
      sh_ri = '1;
   endtask

   // One clock: score the output handshake, model the accept, advance, check operands
   task automatic step();
      exp_t          e;
      logic [VW-1:0] ts, rs;
      logic          was_ena;
      #1;
      was_ena = ena;
      if (ena && out_ready) check_val("in_ready_thru", 32'(in_ready), 32'd1);
      if (!ena) check_val("in_ready_ena_low", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
         check_val("result_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check_val("D", 32'(D), 32'(e.d));
            check_val("o_path", 32'(o_path), 32'(e.path));
            check_val("o_sat", 32'(o_sat), 32'(e.sat));
            if (lat_chk) check_val("latency", 32'(cyc - e.cyc), 32'd2);
         end
      end
      if (ena && in_valid && in_ready) begin
         ts = pick_v(i_tsrc, sh_t, T_prev, T_global);
         rs = pick_v(i_rsrc, sh_r, R_prev, R_global);
         e  = ref_result(ts, rs, D0, D1, D2, mode);
         e.cyc = cyc;
         q.push_back(e);
         sh_t  = ts;
         sh_r  = rs;
         sh_ti = pick_i(i_tsrc, sh_ti, i_tindex_prev, i_tindex_global);
         sh_ri = pick_i(i_rsrc, sh_ri, i_rindex_prev, i_rindex_global);
      end
      if (!ena) model_clear();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_val("T", 32'(T), 32'(sh_t));
      check_val("R", 32'(R), 32'(sh_r));
      check_val("o_tindex", 32'(o_tindex), 32'(sh_ti));
      check_val("o_rindex", 32'(o_rindex), 32'(sh_ri));
      if (!was_ena) begin
         check_val("out_valid_cleared", 32'(out_valid), 32'd0);
         check_val("D_cleared", 32'(D), 32'd0);
      end
   endtask

   // Single transaction with fixed expected result and 2-cycle latency
   task automatic run_one(input string tag, input logic [VW-1:0] tv, input logic [VW-1:0] rv,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                          input logic m, input logic [DW-1:0] xd, input logic [1:0] xp, input logic xs);
      T_global = tv;
      R_global = rv;
      i_tsrc   = 2'd2;
      i_rsrc   = 2'd2;
      D0 = d0; D1 = d1; D2 = d2;
      mode      = m;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      lat_chk   = 1'b1;
      step();
      in_valid = 1'b0;
      check_val({tag, "_valid_early"}, 32'(out_valid), 32'd0);
      step();
      check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, "_D"}, 32'(D), 32'(xd));
      check_val({tag, "_path"}, 32'(o_path), 32'(xp));
      check_val({tag, "_sat"}, 32'(o_sat), 32'(xs));
      step();
      lat_chk = 1'b0;
   endtask

   task automatic randomize_inputs();
      T_prev   = VW'($urandom());
      T_global = VW'($urandom());
      R_prev   = VW'($urandom());
      R_global = VW'($urandom());
      i_tindex_prev   = IW'($urandom());
      i_tindex_global = IW'($urandom());
      i_rindex_prev   = IW'($urandom());
      i_rindex_global = IW'($urandom());
      i_tsrc = 2'($urandom_range(0, 3));
      i_rsrc = 2'($urandom_range(0, 3));
      mode   = 1'($urandom_range(0, 1));
      D0 = ($urandom_range(0, 3) == 0) ? DW'(16'hF000 + $urandom_range(0, 4095)) : DW'($urandom_range(0, 4095));
      D1 = ($urandom_range(0, 3) == 0) ? DW'(16'hF000 + $urandom_range(0, 4095)) : DW'($urandom_range(0, 4095));
      D2 = ($urandom_range(0, 3) == 0) ? DW'(16'hF000 + $urandom_range(0, 4095)) : DW'($urandom_range(0, 4095));
   endtask

   initial begin
      logic [VW-1:0] tv, rv, zv, lv;
      int            idx;
      bit            acc;
      n_chk = 0; n_pass = 0; cyc = 0; lat_chk = 1'b0;
      nrst = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      T_prev = '0; T_global = '0; R_prev = '0; R_global = '0;
      i_tindex_prev = '0; i_tindex_global = '0; i_rindex_prev = '0; i_rindex_global = '0;
      i_tsrc = 2'd0; i_rsrc = 2'd0; mode = 1'b0;
      D0 = '0; D1 = '0; D2 = '0;
      model_clear();

      // Reset state
      repeat (2) @(negedge clk);
      check_val("rst_T", 32'(T), 32'd0);
      check_val("rst_R", 32'(R), 32'd0);
      check_val("rst_tindex", 32'(o_tindex), 32'd31);
      check_val("rst_rindex", 32'(o_rindex), 32'd31);
      check_val("rst_D", 32'(D), 32'd0);
      check_val("rst_path", 32'(o_path), 32'd0);
      check_val("rst_sat", 32'(o_sat), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      nrst = 1'b1;
      ena  = 1'b1;

      // Directed arithmetic cases
      tv = {10'd5, 10'h3FD, 10'd0};
      rv = {10'd1, 10'd4, 10'd0};
      zv = '0;
      lv = {10'd50, 10'd30, 10'd20};
      run_one("l1", tv, rv, 16'd20, 16'd10, 16'd30, 1'b0, 16'd21, 2'b10, 1'b0);
      run_one("linf", tv, rv, 16'd20, 16'd10, 16'd30, 1'b1, 16'd17, 2'b10, 1'b0);
      run_one("tie_all", zv, zv, 16'd7, 16'd7, 16'd7, 1'b0, 16'd7, 2'b11, 1'b0);
      run_one("tie_d1d2", zv, zv, 16'd9, 16'd4, 16'd4, 1'b0, 16'd4, 2'b10, 1'b0);
      run_one("min_d2", zv, zv, 16'd9, 16'd8, 16'd3, 1'b0, 16'd3, 2'b01, 1'b0);
      run_one("sat", zv, lv, 16'hFFFF, 16'hFFF0, 16'hFFFF, 1'b0, 16'hFFFF, 2'b10, 1'b1);

      // Back-to-back accepts with a 3-cycle output stall
      idx = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 0 || acc) randomize_inputs();
         out_ready = !(k >= 2 && k <= 4);
         in_valid  = (idx < 4);
         #1;
         if (k <= 6) check_val("stall_in_ready", 32'(in_ready), 32'(!(k >= 2 && k <= 4)));
         if (!out_ready && q.size() != 0) check_val("stall_D_hold", 32'(D), 32'(q[0].d));
         acc = ena && in_valid && in_ready;
         step();
         if (acc) idx++;
      end
      check_val("stall_accepts", 32'(idx), 32'd4);
      check_val("stall_drained", 32'(q.size()), 32'd0);

      // Hold source, then a one-cycle enable drop
      in_valid = 1'b1; out_ready = 1'b1;
      randomize_inputs();
      i_tsrc = 2'd2; i_tindex_global = 5'd5;
      step();
      i_tsrc = 2'd0;
      step();
      check_val("hold_tindex", 32'(o_tindex), 32'd5);
      in_valid = 1'b0;
      ena = 1'b0;
      step();
      check_val("ena_T", 32'(T), 32'd0);
      check_val("ena_tindex", 32'(o_tindex), 32'd31);
      check_val("ena_out_valid", 32'(out_valid), 32'd0);
      ena = 1'b1;

      // Randomized traffic with an asynchronous reset pulse mid-stream
      for (int n = 0; n < 400; n++) begin
         randomize_inputs();
         ena       = ($urandom_range(0, 19) != 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 2) != 0);
         if (n == 200) begin
            in_valid = 1'b1;
            #2;
            nrst = 1'b0;
            #1;
            check_val("arst_T", 32'(T), 32'd0);
            check_val("arst_tindex", 32'(o_tindex), 32'd31);
            check_val("arst_rindex", 32'(o_rindex), 32'd31);
            check_val("arst_out_valid", 32'(out_valid), 32'd0);
            check_val("arst_D", 32'(D), 32'd0);
            check_val("arst_path", 32'(o_path), 32'd0);
            check_val("arst_sat", 32'(o_sat), 32'd0);
            model_clear();
            @(negedge clk);
            nrst = 1'b1;
         end else begin
            step();
         end
      end

      // Drain
      ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      check_val("final_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dtw_pe_pipe.md
DTW_PE_PIPE -- requirements
Module: dtw_pe_pipe

Interface
REQ-001 SHALL have parameter NDIM, default 3, number of feature channels per vector.
REQ-002 SHALL have parameter FW, default 10, signed feature element width.
REQ-003 SHALL have parameter DW, default 16, unsigned accumulated-distance width.
REQ-004 SHALL have parameter IW, default 5, index width.
REQ-005 SHALL have one clock; reset is asynchronous and active-low (ports clk, nrst).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 nrst  input  1  asynchronous active-low reset.
REQ-008 ena  input  1  synchronous enable; low clears the block.
REQ-009 in_valid  input  1 / in_ready  output  1  input handshake.
REQ-010 D0, D1, D2  input  DW each  predecessor costs (i-1,j-1), (i-1,j), (i,j-1).
REQ-011 T_prev, T_global, R_prev, R_global  input  NDIM*FW each  packed vectors, channel k at bits [k*FW +: FW].
REQ-012 i_tindex_prev, i_tindex_global, i_rindex_prev, i_rindex_global  input  IW each  vector indices.
REQ-013 i_tsrc, i_rsrc  input  2 each  source select: 0 hold, 1 prev, 2 global, 3 hold.
REQ-014 mode  input  1  local metric: 0 L1 (sum of absolute differences), 1 L-inf (max absolute difference).
REQ-015 T, R  output  NDIM*FW each / o_tindex, o_rindex  output  IW each  registered operands for systolic chaining.
REQ-016 out_valid  input-side output  1 / out_ready  input  1  output handshake.
REQ-017 D  output  DW / o_path  output  2 / o_sat  output  1  result cost, path, saturation flag.

Function
REQ-018 Input accept SHALL occur when in_valid & in_ready & ena; T/R and indices SHALL update only on accept.
REQ-019 On accept, T SHALL load the selected source; o_tindex SHALL load the prev/global index for tsrc 1/2 and hold for tsrc 0/3; R/o_rindex identically with rsrc.
REQ-020 Stage 1 SHALL use the selected (pre-register) T/R values, per channel compute |R_k - T_k| using FW+1-bit signed subtraction, no overflow.
REQ-021 Local distance SHALL be the sum (mode 0) or maximum (mode 1) of channel absolutes, width FW+1+clog2(NDIM), zero-extended.
REQ-022 Minimum SHALL pick the smallest of D0, D1, D2; ties resolved D0 over D1 over D2; o_path 2'b11 D0, 2'b10 D1, 2'b01 D2.
REQ-023 Stage 1 SHALL register local distance, minimum, path, mode-independent result; stage 2 SHALL register D = local + min.
REQ-024 If local + min > 2^DW-1, D SHALL be 2^DW-1 and o_sat 1; else o_sat 0.
REQ-025 Latency SHALL be 2 cycles: accept at edge n -> out_valid at edge n+2 absent stall.
REQ-026 Stage 2 advances when ~out_valid | out_ready; in_ready SHALL be ~s1_valid | stage-2-advance (combinational, no dependency on in_valid).
REQ-027 While out_valid & ~out_ready, D, o_path, o_sat SHALL hold stable; no result SHALL be lost or duplicated.
REQ-028 Throughput SHALL be one result per cycle when out_ready held high.
REQ-029 ena low SHALL at the next edge clear both pipeline valid bits, T/R to 0, indices to all-ones; D, o_path, o_sat to 0; in_ready SHALL be 0 while ena low.

Reset
REQ-030 nrst low SHALL asynchronously set T=0, R=0, o_tindex=o_rindex=all-ones, D=0, o_path=2'b00, o_sat=0, out_valid=0, stage-1 valid=0.
REQ-031 Reset mid-transaction SHALL discard all in-flight results; first accept after release behaves as from idle.

Verification
REQ-032 Defaults, mode 0, tsrc=rsrc=2, T_global={10'd5,10'd-3,10'd0}, R_global={10'd1,10'd4,10'd0}, D0=20,D1=10,D2=30, out_ready=1 -> 2 cycles later out_valid=1, D=21, o_path=2'b10, o_sat=0.
REQ-033 Same vectors, mode 1 -> D=17, o_path=2'b10.
REQ-034 D0=D1=D2=7, zero vectors -> D=7, o_path=2'b11; D0=9,D1=D2=4 -> o_path=2'b10.
REQ-035 D1=16'hFFF0 min, local 100 -> D=16'hFFFF, o_sat=1.
REQ-036 Back-to-back 4 accepts, out_ready low for 3 cycles after first out_valid -> in_ready drops after 2 pending, results emerge in order unchanged.
REQ-037 tsrc=0 after load, then ena low one cycle -> T=0, o_tindex=5'd31, out_valid=0; nrst pulse mid-stream -> all REQ-030 values immediately.
